// File: rtl/vigenere_stream_cipher.sv
// rtl/vigenere_stream_cipher.sv - streaming Vigenere encrypt/decrypt engine with valid/ready flow control
module vigenere_stream_cipher #(
    parameter int KEY_LEN      = 3,
    parameter int LETTERS_ONLY = 1
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       key_wr_en,
    input  logic [((KEY_LEN > 1) ? $clog2(KEY_LEN) : 1)-1:0] key_wr_idx,
    input  logic [7:0]                                 key_wr_data,
    input  logic                                       start,
    input  logic                                       mode,
    input  logic                                       s_valid,
    output logic                                       s_ready,
    input  logic [7:0]                                 s_data,
    input  logic                                       s_last,
    output logic                                       m_valid,
    input  logic                                       m_ready,
    output logic [7:0]                                 m_data,
    output logic                                       m_last,
    output logic                                       busy
);

    localparam int IDX_W = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;

    logic [7:0]         key_regs [KEY_LEN];
    logic [IDX_W-1:0]   key_idx;
    logic               mode_q;

    logic               accept;
    logic               out_taken;

    logic [7:0]         key_byte;
    logic [7:0]         key_shift;
    logic [7:0]         base;
    logic [7:0]         off;
    logic [7:0]         sum;
    logic               is_upper;
    logic               is_lower;
    logic               key_upper;
    logic               key_lower;
    logic [7:0]         xf_data;
    logic               xf_advance;

    assign accept    = s_valid & s_ready;
    assign out_taken = m_valid & m_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: a message runs until its last byte is accepted, then drains the output register
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start)                 state_d = ST_RUN;
            ST_RUN:   if (accept && s_last)      state_d = ST_FLUSH;
            ST_FLUSH: if (out_taken && m_last)   state_d = ST_IDLE;
            default:                             state_d = ST_IDLE;
        endcase
    end

    // Output decode: input is only taken while running and the output slot is free or draining
    always_comb begin
        s_ready = 1'b0;
        busy    = 1'b0;
        if (state_q == ST_RUN) begin
            s_ready = ~m_valid | m_ready;
        end
        if (state_q != ST_IDLE) begin
            busy = 1'b1;
        end
    end

    // Byte transform: letter-preserving mod-26 shift or raw mod-256 add/subtract
    always_comb begin
        key_byte   = key_regs[key_idx];
        key_upper  = (key_byte >= 8'h41) && (key_byte <= 8'h5A);
        key_lower  = (key_byte >= 8'h61) && (key_byte <= 8'h7A);
        is_upper   = (s_data >= 8'h41) && (s_data <= 8'h5A);
        is_lower   = (s_data >= 8'h61) && (s_data <= 8'h7A);
        key_shift  = 8'(key_byte % 8'd26);
        if (key_upper) begin
            key_shift = key_byte - 8'h41;
        end else if (key_lower) begin
            key_shift = key_byte - 8'h61;
        end
        base = is_lower ? 8'h61 : 8'h41;
        off  = s_data - base;
        // Both sums stay below 52, so one conditional subtract gives the mod-26 result
        if (mode_q) begin
            sum = off + 8'd26 - key_shift;
        end else begin
            sum = off + key_shift;
        end
        if (sum >= 8'd26) begin
            sum = sum - 8'd26;
        end
        xf_data    = s_data;
        xf_advance = 1'b1;
        if (LETTERS_ONLY != 0) begin
            if (is_upper || is_lower) begin
                xf_data = base + sum;
            end else begin
                xf_advance = 1'b0;
            end
        end else begin
            xf_data = mode_q ? (s_data - key_byte) : (s_data + key_byte);
        end
    end

    // Key storage: writable only between messages so a message always sees one key
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < KEY_LEN; i++) begin
                key_regs[i] <= 8'h00;
            end
        end else if ((state_q == ST_IDLE) && key_wr_en && (32'(key_wr_idx) < KEY_LEN)) begin
            key_regs[key_wr_idx] <= key_wr_data;
        end
    end

    // Key index and mode: restart at slot 0 on start, step on every transformed accepted beat
    always_ff @(posedge clk) begin
        if (rst) begin
            key_idx <= '0;
            mode_q  <= 1'b0;
        end else if ((state_q == ST_IDLE) && start) begin
            key_idx <= '0;
            mode_q  <= mode;
        end else if (accept && xf_advance) begin
            if (key_idx == IDX_W'(KEY_LEN - 1)) begin
                key_idx <= '0;
            end else begin
                key_idx <= key_idx + 1'b1;
            end
        end
    end

    // Output register: loads on accept, holds under backpressure, empties when taken
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_data  <= 8'h00;
            m_last  <= 1'b0;
        end else if (accept) begin
            m_valid <= 1'b1;
            m_data  <= xf_data;
            m_last  <= s_last;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule
